// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename status (busy bit + ROB tag).
// Supports several combinational read ports, one rename and one commit per cycle, plus a busy-register counter.
module rename_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RIDX_W = 5,
  parameter int ROB_W  = 4,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRD-1:0]        rs_en,
  input  logic [NRD*RIDX_W-1:0] rs_addr,
  output logic [NRD-1:0]        rs_busy,
  output logic [NRD*XLEN-1:0]   rs_value,
  output logic [NRD*ROB_W-1:0]  rs_tag,
  input  logic                  ren_en,
  input  logic [RIDX_W-1:0]     ren_rd,
  input  logic [ROB_W-1:0]      ren_tag,
  input  logic                  cmt_en,
  input  logic [RIDX_W-1:0]     cmt_rd,
  input  logic [ROB_W-1:0]      cmt_tag,
  input  logic [XLEN-1:0]       cmt_value,
  input  logic                  flush,
  output logic [RIDX_W:0]       busy_count
);

  logic [XLEN-1:0]  reg_value [NREG];
  logic [ROB_W-1:0] reg_tag   [NREG];
  logic [NREG-1:0]  reg_busy;

  logic [NREG-1:0]  busy_nxt;
  logic [RIDX_W:0]  count_nxt;
  logic             cmt_ok;
  logic             ren_ok;
  logic             cmt_clears;

  // Writable means a real, in-range register other than the hardwired x0.
  function automatic logic writable(input logic [RIDX_W-1:0] a);
    return (a != '0) && (32'(a) < 32'(NREG));
  endfunction

  assign cmt_ok     = cmt_en && writable(cmt_rd);
  assign ren_ok     = ren_en && writable(ren_rd) && !flush;
  assign cmt_clears = cmt_ok && reg_busy[cmt_rd] && (reg_tag[cmt_rd] == cmt_tag);

  // Rename is applied after commit so it wins busy/tag when both hit the same register.
  always_comb begin
    busy_nxt = reg_busy;
    if (cmt_clears) busy_nxt[cmt_rd] = 1'b0;
    if (flush) busy_nxt = '0;
    else if (ren_ok) busy_nxt[ren_rd] = 1'b1;
    count_nxt = '0;
    for (int i = 0; i < NREG; i++) count_nxt = count_nxt + (RIDX_W+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        reg_value[i] <= '0;
        reg_tag[i]   <= '0;
      end
      reg_busy   <= '0;
      busy_count <= '0;
    end else if (rdy) begin
      if (cmt_ok) reg_value[cmt_rd] <= cmt_value;
      if (ren_ok) reg_tag[ren_rd] <= ren_tag;
      reg_busy   <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_read
    logic [RIDX_W-1:0] addr;
    logic              busy_p;
    logic [XLEN-1:0]   value_p;
    logic [ROB_W-1:0]  tag_p;

    assign addr = rs_addr[p*RIDX_W +: RIDX_W];

    // A commit that would clear this register forwards its value in the same cycle.
    always_comb begin
      busy_p  = 1'b0;
      value_p = '0;
      tag_p   = '0;
      if (rs_en[p] && writable(addr)) begin
        tag_p = reg_tag[addr];
        if (cmt_en && rdy && (cmt_rd == addr) && reg_busy[addr] && (reg_tag[addr] == cmt_tag)) begin
          value_p = cmt_value;
        end else begin
          busy_p  = reg_busy[addr];
          value_p = reg_value[addr];
        end
      end
    end

    assign rs_busy[p]                = busy_p;
    assign rs_value[p*XLEN +: XLEN]  = value_p;
    assign rs_tag[p*ROB_W +: ROB_W]  = tag_p;
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expected read/count values are queued per cycle
// from the test plan and drained against the DUT just after inputs settle.
module tb_rename_regfile;

  localparam int XLEN = 32, RIDX_W = 5, ROB_W = 4, NRD = 2;

  logic                  clk = 1'b0;
  logic                  rst, rdy;
  logic [NRD-1:0]        rs_en;
  logic [NRD*RIDX_W-1:0] rs_addr;
  logic [NRD-1:0]        rs_busy;
  logic [NRD*XLEN-1:0]   rs_value;
  logic [NRD*ROB_W-1:0]  rs_tag;
  logic                  ren_en;
  logic [RIDX_W-1:0]     ren_rd;
  logic [ROB_W-1:0]      ren_tag;
  logic                  cmt_en;
  logic [RIDX_W-1:0]     cmt_rd;
  logic [ROB_W-1:0]      cmt_tag;
  logic [XLEN-1:0]       cmt_value;
  logic                  flush;
  logic [RIDX_W:0]       busy_count;

  int checks = 0;
  int errors = 0;

  typedef enum int {K_BUSY, K_VALUE, K_TAG, K_COUNT} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    int          port;
    logic [31:0] exp;
  } exp_t;
  exp_t sb [$];

  rename_regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_en(rs_en), .rs_addr(rs_addr),
    .rs_busy(rs_busy), .rs_value(rs_value), .rs_tag(rs_tag),
    .ren_en(ren_en), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_value(cmt_value),
    .flush(flush), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] observe(input kind_t k, input int p);
    case (k)
      K_BUSY:  return 32'(rs_busy[p]);
      K_VALUE: return rs_value[p*XLEN +: XLEN];
      K_TAG:   return 32'(rs_tag[p*ROB_W +: ROB_W]);
      default: return 32'(busy_count);
    endcase
  endfunction

  task automatic expect_val(input string nm, input kind_t k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.kind = k; e.port = p; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic set_read(input int p, input logic [RIDX_W-1:0] a);
    rs_en[p] = 1'b1;
    rs_addr[p*RIDX_W +: RIDX_W] = a;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rs_en = '0; rs_addr = '0;
    ren_en = 1'b0; ren_rd = '0; ren_tag = '0;
    cmt_en = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_value = '0; flush = 1'b0;
  endtask

  // Inputs for this cycle are already set (after a negedge); settle, drain the scoreboard, advance.
  task automatic applyStimulus();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.name, observe(e.kind, e.port), e.exp);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    idle();

    // 1: post-reset reads, with a rename of x5 that must not be visible yet
    set_read(0, 5); set_read(1, 5);
    ren_en = 1; ren_rd = 5; ren_tag = 3;
    expect_val("rst_busy0", K_BUSY, 0, 0);  expect_val("rst_val0", K_VALUE, 0, 0);
    expect_val("rst_busy1", K_BUSY, 1, 0);  expect_val("rst_val1", K_VALUE, 1, 0);
    expect_val("rst_count", K_COUNT, 0, 0);
    applyStimulus();

    // 2: x5 busy tag 3; rename again with tag 7
    set_read(0, 5);
    ren_en = 1; ren_rd = 5; ren_tag = 7;
    expect_val("ren_busy", K_BUSY, 0, 1); expect_val("ren_tag", K_TAG, 0, 3);
    expect_val("ren_count", K_COUNT, 0, 1);
    applyStimulus();

    // 3: stale commit tag 3 must not clear busy
    set_read(0, 5);
    cmt_en = 1; cmt_rd = 5; cmt_tag = 3; cmt_value = 32'hAA;
    expect_val("stale_busy", K_BUSY, 0, 1); expect_val("stale_tag", K_TAG, 0, 7);
    applyStimulus();

    set_read(1, 5);
    expect_val("stale_busy2", K_BUSY, 1, 1); expect_val("stale_tag2", K_TAG, 1, 7);
    expect_val("stale_val", K_VALUE, 1, 32'hAA); expect_val("stale_count", K_COUNT, 0, 1);
    applyStimulus();

    // matching commit with same-cycle bypass on both ports
    set_read(0, 5); set_read(1, 5);
    cmt_en = 1; cmt_rd = 5; cmt_tag = 7; cmt_value = 32'hBB;
    expect_val("byp_busy0", K_BUSY, 0, 0); expect_val("byp_val0", K_VALUE, 0, 32'hBB);
    expect_val("byp_busy1", K_BUSY, 1, 0); expect_val("byp_val1", K_VALUE, 1, 32'hBB);
    applyStimulus();

    set_read(0, 5);
    expect_val("cmt_busy", K_BUSY, 0, 0); expect_val("cmt_val", K_VALUE, 0, 32'hBB);
    expect_val("cmt_count", K_COUNT, 0, 0);
    applyStimulus();

    // 4: commit and rename x6 in one cycle
    set_read(0, 6);
    cmt_en = 1; cmt_rd = 6; cmt_tag = 2; cmt_value = 32'h11;
    ren_en = 1; ren_rd = 6; ren_tag = 4;
    expect_val("same_pre_busy", K_BUSY, 0, 0); expect_val("same_pre_val", K_VALUE, 0, 0);
    applyStimulus();

    set_read(0, 6);
    ren_en = 1; ren_rd = 7; ren_tag = 1;
    expect_val("same_busy", K_BUSY, 0, 1); expect_val("same_tag", K_TAG, 0, 4);
    expect_val("same_val", K_VALUE, 0, 32'h11); expect_val("same_count", K_COUNT, 0, 1);
    applyStimulus();

    // 5: third busy register, then flush with commit
    ren_en = 1; ren_rd = 8; ren_tag = 5;
    expect_val("three_count_a", K_COUNT, 0, 2);
    applyStimulus();

    set_read(0, 7);
    flush = 1;
    cmt_en = 1; cmt_rd = 7; cmt_tag = 9; cmt_value = 32'h55;
    ren_en = 1; ren_rd = 9; ren_tag = 6;
    expect_val("fl_pre_busy", K_BUSY, 0, 1); expect_val("fl_pre_tag", K_TAG, 0, 1);
    expect_val("three_count_b", K_COUNT, 0, 3);
    applyStimulus();

    set_read(0, 7); set_read(1, 9);
    expect_val("fl_busy7", K_BUSY, 0, 0); expect_val("fl_val7", K_VALUE, 0, 32'h55);
    expect_val("fl_busy9", K_BUSY, 1, 0); expect_val("fl_count", K_COUNT, 0, 0);
    applyStimulus();

    // 6: x0 writes ignored
    ren_en = 1; ren_rd = 0; ren_tag = 6;
    cmt_en = 1; cmt_rd = 0; cmt_tag = 0; cmt_value = 32'hFF;
    applyStimulus();

    set_read(0, 0); set_read(1, 0);
    ren_en = 1; ren_rd = 8; ren_tag = 2;
    expect_val("x0_busy", K_BUSY, 0, 0); expect_val("x0_val", K_VALUE, 0, 0);
    expect_val("x0_tag", K_TAG, 1, 0); expect_val("x0_count", K_COUNT, 0, 0);
    applyStimulus();

    // rdy=0: rename/commit held off, no bypass; disabled port reads zero
    rdy = 0;
    set_read(0, 8);
    rs_addr[RIDX_W +: RIDX_W] = 8;
    ren_en = 1; ren_rd = 8; ren_tag = 3;
    cmt_en = 1; cmt_rd = 8; cmt_tag = 2; cmt_value = 32'h77;
    expect_val("hold_busy", K_BUSY, 0, 1); expect_val("hold_tag", K_TAG, 0, 2);
    expect_val("dis_busy", K_BUSY, 1, 0); expect_val("dis_val", K_VALUE, 1, 0);
    expect_val("hold_count_a", K_COUNT, 0, 1);
    applyStimulus();

    set_read(0, 8);
    expect_val("held_busy", K_BUSY, 0, 1); expect_val("held_tag", K_TAG, 0, 2);
    expect_val("held_val", K_VALUE, 0, 0); expect_val("hold_count_b", K_COUNT, 0, 1);
    applyStimulus();

    // reset with rdy=0 still clears
    rst = 1; rdy = 0;
    applyStimulus();
    set_read(0, 8); set_read(1, 5);
    expect_val("rst2_busy", K_BUSY, 0, 0); expect_val("rst2_val", K_VALUE, 1, 0);
    expect_val("rst2_count", K_COUNT, 0, 0);
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
